// File: rtl/regfile_scb.sv
// Register file with per-register pending (scoreboard) bits, optional write-to-read
// forwarding, and a sequenced bulk clear that walks registers 1..NREG-1.
module regfile_scb #(
  parameter int  XLEN   = 32,
  parameter int  NREG   = 32,
  parameter int  BYPASS = 1,
  localparam int AW     = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            res_n,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  input  logic [AW-1:0]   rd,
  input  logic            reg_write,
  input  logic [XLEN-1:0] wr_data,
  output logic [XLEN-1:0] reg1,
  output logic [XLEN-1:0] reg2,
  input  logic            alloc_valid,
  input  logic [AW-1:0]   alloc_rd,
  output logic            busy1,
  output logic            busy2,
  input  logic            clr_req,
  output logic            clr_busy,
  output logic            clr_done
);

  // state   | meaning
  // S_IDLE  | normal operation, waiting for clr_req
  // S_CLEAR | zeroing mem[idx] and busy[idx], idx = 1..NREG-1
  // S_DONE  | one-cycle clr_done pulse, still blocking writes
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [XLEN-1:0] mem_q [NREG];
  logic [XLEN-1:0] mem_d [NREG];
  logic [NREG-1:0] busy_q, busy_d;

  logic wr_en;
  logic alloc_en;
  logic byp_ok;
  logic hit1;
  logic hit2;

  assign clr_busy = (state_q != S_IDLE);
  assign wr_en    = reg_write && (rd != '0) && !clr_busy;
  assign alloc_en = alloc_valid && (alloc_rd != '0) && !clr_busy;

  // Forwarding is gated by res_n so the read ports stay at zero during reset.
  assign byp_ok = (BYPASS != 0) && res_n && wr_en;
  assign hit1   = byp_ok && (rd == rs1);
  assign hit2   = byp_ok && (rd == rs2);

  always_comb begin
    reg1 = '0;
    if (rs1 != '0) reg1 = hit1 ? wr_data : mem_q[rs1];
  end

  always_comb begin
    reg2 = '0;
    if (rs2 != '0) reg2 = hit2 ? wr_data : mem_q[rs2];
  end

  assign busy1 = (rs1 != '0) && busy_q[rs1] && !hit1;
  assign busy2 = (rs2 != '0) && busy_q[rs2] && !hit2;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    clr_done = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (clr_req) begin
          state_d = S_CLEAR;
          idx_d   = AW'(1);
        end
      end
      S_CLEAR: begin
        idx_d = idx_q + AW'(1);
        if (idx_q == AW'(NREG - 1)) begin
          state_d = S_DONE;
          idx_d   = '0;
        end
      end
      S_DONE: begin
        clr_done = 1'b1;
        state_d  = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // Alloc is applied after the write so a same-edge alloc keeps the bit set.
  always_comb begin
    mem_d  = mem_q;
    busy_d = busy_q;
    if (state_q == S_CLEAR) begin
      mem_d[idx_q]  = '0;
      busy_d[idx_q] = 1'b0;
    end else begin
      if (wr_en) begin
        mem_d[rd]  = wr_data;
        busy_d[rd] = 1'b0;
      end
      if (alloc_en) busy_d[alloc_rd] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      busy_q  <= '0;
      for (int i = 0; i < NREG; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      mem_q   <= mem_d;
    end
  end

endmodule

// File: tb/tb_regfile_scb.sv
// Bench for regfile_scb: a forwarding and a non-forwarding instance share stimulus and
// are checked against directed vectors and an abstract register/scoreboard model.
module tb_regfile_scb;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;

  logic            clk;
  logic            res_n;
  logic [AW-1:0]   rs1, rs2, rd, alloc_rd;
  logic            reg_write, alloc_valid, clr_req;
  logic [XLEN-1:0] wr_data;

  logic [XLEN-1:0] b_reg1, b_reg2, nb_reg1, nb_reg2;
  logic            b_busy1, b_busy2, nb_busy1, nb_busy2;
  logic            b_clr_busy, b_clr_done, nb_clr_busy, nb_clr_done;

  int n_cmp = 0;
  int n_err = 0;

  regfile_scb #(.XLEN(XLEN), .NREG(NREG), .BYPASS(1)) u_b (
    .clk(clk), .res_n(res_n), .rs1(rs1), .rs2(rs2), .rd(rd), .reg_write(reg_write),
    .wr_data(wr_data), .reg1(b_reg1), .reg2(b_reg2), .alloc_valid(alloc_valid),
    .alloc_rd(alloc_rd), .busy1(b_busy1), .busy2(b_busy2), .clr_req(clr_req),
    .clr_busy(b_clr_busy), .clr_done(b_clr_done)
  );

  regfile_scb #(.XLEN(XLEN), .NREG(NREG), .BYPASS(0)) u_nb (
    .clk(clk), .res_n(res_n), .rs1(rs1), .rs2(rs2), .rd(rd), .reg_write(reg_write),
    .wr_data(wr_data), .reg1(nb_reg1), .reg2(nb_reg2), .alloc_valid(alloc_valid),
    .alloc_rd(alloc_rd), .busy1(nb_busy1), .busy2(nb_busy2), .clr_req(clr_req),
    .clr_busy(nb_clr_busy), .clr_done(nb_clr_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  // Reference model: register contents, pending bits, and clear progress
  // (clr_pos 0 = idle, 1..NREG-1 = register being cleared this cycle, NREG = done cycle).
  logic [XLEN-1:0] mem_m [NREG];
  logic            busy_m [NREG];
  int              clr_pos;

  always @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      for (int i = 0; i < NREG; i++) begin
        mem_m[i]  = '0;
        busy_m[i] = 1'b0;
      end
      clr_pos = 0;
    end else if (clr_pos == 0) begin
      if (reg_write && rd != 0) begin
        mem_m[rd]  = wr_data;
        busy_m[rd] = 1'b0;
      end
      if (alloc_valid && alloc_rd != 0) busy_m[alloc_rd] = 1'b1;
      if (clr_req) clr_pos = 1;
    end else if (clr_pos < NREG) begin
      mem_m[clr_pos]  = '0;
      busy_m[clr_pos] = 1'b0;
      clr_pos++;
    end else begin
      clr_pos = 0;
    end
  end

  function automatic logic fwd(input logic [AW-1:0] a, input bit byp);
    return byp && res_n && reg_write && clr_pos == 0 && rd != 0 && rd == a;
  endfunction

  function automatic logic [XLEN-1:0] exp_reg(input logic [AW-1:0] a, input bit byp);
    if (!res_n || a == 0) return '0;
    if (fwd(a, byp)) return wr_data;
    return mem_m[a];
  endfunction

  function automatic logic exp_busy(input logic [AW-1:0] a, input bit byp);
    if (!res_n || a == 0) return 1'b0;
    return busy_m[a] && !fwd(a, byp);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  task automatic idle_inputs();
    reg_write   = 1'b0;
    alloc_valid = 1'b0;
    clr_req     = 1'b0;
    rd          = '0;
    alloc_rd    = '0;
    wr_data     = '0;
  endtask

  task automatic sweep_zero(input string nm);
    idle_inputs();
    for (int a = 0; a < NREG; a++) begin
      rs1 = AW'(a);
      rs2 = AW'(NREG - 1 - a);
      #1;
      chk({nm, " reg1"}, b_reg1, 0);
      chk({nm, " reg2"}, b_reg2, 0);
      chk({nm, " busy1"}, b_busy1, 0);
      chk({nm, " busy2"}, nb_busy2, 0);
    end
  endtask

  task automatic fill_regs();
    for (int i = 1; i < NREG; i++) begin
      @(negedge clk);
      reg_write   = 1'b1;
      rd          = AW'(i);
      wr_data     = (i * 32'h01010101) ^ 32'h8000_0000;
      alloc_valid = 1'b1;
      alloc_rd    = AW'(i);
    end
    @(negedge clk);
    idle_inputs();
    rs1 = 5'd17;
    rs2 = 5'd31;
    #1;
    chk("fill reg1", b_reg1, (17 * 32'h01010101) ^ 32'h8000_0000);
    chk("fill busy1", b_busy1, 1);
    chk("fill busy2", b_busy2, 1);
  endtask

  task automatic run_clear(input string nm);
    int busy_cycles;
    int done_pulses;
    busy_cycles = 0;
    done_pulses = 0;
    @(negedge clk);
    idle_inputs();
    clr_req = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 40; k++) begin
      idle_inputs();
      if (k == 4) begin
        reg_write = 1'b1;
        rd        = 5'd4;
        wr_data   = 32'hBAD0_BAD0;
      end
      if (k == 6) clr_req = 1'b1;
      if (k == 8) begin
        alloc_valid = 1'b1;
        alloc_rd    = 5'd4;
      end
      #1;
      if (b_clr_busy) busy_cycles++;
      if (b_clr_done) done_pulses++;
      @(negedge clk);
    end
    idle_inputs();
    chk({nm, " clr_busy cycles"}, busy_cycles, 32);
    chk({nm, " clr_done pulses"}, done_pulses, 1);
    sweep_zero({nm, " after"});
  endtask

  typedef struct {
    logic [AW-1:0]   rs1, rs2, rd;
    logic            we;
    logic [XLEN-1:0] wd;
    logic            av;
    logic [AW-1:0]   ard;
    logic [XLEN-1:0] r1, r2;
    logic            b1, b2;
    logic [XLEN-1:0] nb_r2;
  } vec_t;

  vec_t tbl [10];

  initial begin
    tbl[0] = '{5'd5, 5'd0, 5'd5, 1'b1, 32'hDEADBEEF, 1'b0, 5'd0, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0, 32'h0};
    tbl[1] = '{5'd5, 5'd5, 5'd0, 1'b1, 32'h00001234, 1'b0, 5'd0, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0, 32'hDEADBEEF};
    tbl[2] = '{5'd0, 5'd5, 5'd0, 1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0, 32'hDEADBEEF};
    tbl[3] = '{5'd3, 5'd7, 5'd7, 1'b1, 32'hA5A5A5A5, 1'b1, 5'd3, 32'h0, 32'hA5A5A5A5, 1'b0, 1'b0, 32'h0};
    tbl[4] = '{5'd3, 5'd7, 5'd0, 1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 32'hA5A5A5A5, 1'b1, 1'b0, 32'hA5A5A5A5};
    tbl[5] = '{5'd3, 5'd3, 5'd3, 1'b1, 32'h00000011, 1'b0, 5'd0, 32'h11, 32'h11, 1'b0, 1'b0, 32'h0};
    tbl[6] = '{5'd3, 5'd3, 5'd3, 1'b1, 32'h00000022, 1'b1, 5'd3, 32'h22, 32'h22, 1'b0, 1'b0, 32'h11};
    tbl[7] = '{5'd3, 5'd0, 5'd0, 1'b0, 32'h0, 1'b0, 5'd0, 32'h22, 32'h0, 1'b1, 1'b0, 32'h0};
    tbl[8] = '{5'd0, 5'd0, 5'd0, 1'b1, 32'h0000FFFF, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0};
    tbl[9] = '{5'd7, 5'd5, 5'd0, 1'b0, 32'h0, 1'b0, 5'd0, 32'hA5A5A5A5, 32'hDEADBEEF, 1'b0, 1'b0, 32'hDEADBEEF};

    res_n = 1'b0;
    rs1   = 5'd9;
    rs2   = 5'd9;
    idle_inputs();
    #1;
    chk("reset reg1", b_reg1, 0);
    chk("reset busy1", b_busy1, 0);
    chk("reset clr_busy", b_clr_busy, 0);
    chk("reset clr_done", b_clr_done, 0);
    repeat (2) @(negedge clk);
    res_n = 1'b1;

    for (int v = 0; v < 10; v++) begin
      @(negedge clk);
      rs1         = tbl[v].rs1;
      rs2         = tbl[v].rs2;
      rd          = tbl[v].rd;
      reg_write   = tbl[v].we;
      wr_data     = tbl[v].wd;
      alloc_valid = tbl[v].av;
      alloc_rd    = tbl[v].ard;
      clr_req     = 1'b0;
      #1;
      chk($sformatf("vec%0d reg1", v), b_reg1, tbl[v].r1);
      chk($sformatf("vec%0d reg2", v), b_reg2, tbl[v].r2);
      chk($sformatf("vec%0d busy1", v), b_busy1, tbl[v].b1);
      chk($sformatf("vec%0d busy2", v), b_busy2, tbl[v].b2);
      chk($sformatf("vec%0d nb reg2", v), nb_reg2, tbl[v].nb_r2);
    end

    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      rd          = AW'($urandom_range(0, NREG - 1));
      reg_write   = ($urandom_range(0, 2) != 0);
      wr_data     = $urandom;
      alloc_valid = ($urandom_range(0, 1) != 0);
      alloc_rd    = ($urandom_range(0, 3) == 0) ? rd : AW'($urandom_range(0, NREG - 1));
      rs1         = ($urandom_range(0, 3) == 0) ? rd : AW'($urandom_range(0, NREG - 1));
      rs2         = ($urandom_range(0, 4) == 0) ? rs1 : AW'($urandom_range(0, NREG - 1));
      clr_req     = ($urandom_range(0, 59) == 0);
      #1;
      chk("rand b reg1", b_reg1, exp_reg(rs1, 1));
      chk("rand b reg2", b_reg2, exp_reg(rs2, 1));
      chk("rand b busy1", b_busy1, exp_busy(rs1, 1));
      chk("rand b busy2", b_busy2, exp_busy(rs2, 1));
      chk("rand nb reg1", nb_reg1, exp_reg(rs1, 0));
      chk("rand nb reg2", nb_reg2, exp_reg(rs2, 0));
      chk("rand nb busy1", nb_busy1, exp_busy(rs1, 0));
      chk("rand nb busy2", nb_busy2, exp_busy(rs2, 0));
      chk("rand clr_busy", b_clr_busy, clr_pos != 0);
      chk("rand clr_done", b_clr_done, clr_pos == NREG);
      chk("rand nb clr_busy", nb_clr_busy, clr_pos != 0);
    end

    @(negedge clk);
    idle_inputs();
    for (int w = 0; w < 40 && clr_pos != 0; w++) @(negedge clk);

    fill_regs();
    run_clear("clear1");

    fill_regs();
    @(negedge clk);
    clr_req = 1'b1;
    @(negedge clk);
    clr_req = 1'b0;
    repeat (9) @(negedge clk);
    chk("midclear busy before reset", b_clr_busy, 1);
    rs1       = 5'd6;
    rs2       = 5'd6;
    rd        = 5'd6;
    reg_write = 1'b1;
    wr_data   = 32'h0000_0055;
    res_n     = 1'b0;
    #1;
    chk("midclear clr_busy", b_clr_busy, 0);
    chk("midclear clr_done", b_clr_done, 0);
    chk("midclear reg1 in reset", b_reg1, 0);
    chk("midclear reg2 in reset", b_reg2, 0);
    sweep_zero("midclear reset");
    @(negedge clk);
    res_n = 1'b1;
    #1;
    chk("post reset clr_busy", b_clr_busy, 0);
    @(negedge clk);
    #1;
    chk("post reset idle", b_clr_busy, 0);

    fill_regs();
    run_clear("clear2");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_scb.md
REGFILE_SCB -- requirements
Module: regfile_scb

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width of each register.
REQ-002 SHALL have parameter NREG, default 32, number of architectural registers (power of two, >= 4).
REQ-003 SHALL have parameter BYPASS, default 1, enables write-to-read forwarding.
REQ-004 SHALL have derived localparam AW = clog2(NREG), register address width.
REQ-005 SHALL have port clk  input  1  single clock, rising edge.
REQ-006 SHALL have port res_n  input  1  reset, asynchronous assert, active-low.
REQ-007 SHALL have ports rs1, rs2  input  AW  read addresses.
REQ-008 SHALL have port rd  input  AW  write address.
REQ-009 SHALL have port reg_write  input  1  write enable.
REQ-010 SHALL have port wr_data  input  XLEN  write data.
REQ-011 SHALL have ports reg1, reg2  output  XLEN  read data for rs1 and rs2.
REQ-012 SHALL have port alloc_valid  input  1  mark a register as pending a result.
REQ-013 SHALL have port alloc_rd  input  AW  register to mark pending.
REQ-014 SHALL have ports busy1, busy2  output  1  pending status of rs1 and rs2.
REQ-015 SHALL have port clr_req  input  1  request a bulk clear of all registers.
REQ-016 SHALL have port clr_busy  output  1  bulk clear in progress.
REQ-017 SHALL have port clr_done  output  1  one-cycle pulse when the bulk clear completes.

Function
REQ-018 SHALL read combinationally: reg1 = mem[rs1] and reg2 = mem[rs2]; an address of 0 SHALL always return 0.
REQ-019 SHALL perform the write on the rising clk edge when reg_write=1, rd!=0 and clr_busy=0; the result SHALL be visible on reads in the following cycle.
REQ-020 SHALL, when BYPASS=1, reg_write=1, clr_busy=0, rd!=0 and rsX==rd, drive regX = wr_data in the same cycle; when BYPASS=0, regX SHALL show the old value until the edge.
REQ-021 SHALL ignore writes to register 0; mem[0] SHALL remain 0 at all times.
REQ-022 SHALL keep a per-register busy bit; alloc_valid=1 with alloc_rd!=0 and clr_busy=0 SHALL set busy[alloc_rd] at the edge.
REQ-023 SHALL clear busy[rd] at the edge of a qualifying write (REQ-019).
REQ-024 SHALL, on the same-edge alloc and write to the same register, leave busy set (the set wins; this models a new producer).
REQ-025 SHALL drive busyX = busy[rsX] & ~(BYPASS & reg_write & ~clr_busy & rd==rsX & rd!=0); busyX SHALL be 0 for rsX=0.
REQ-026 SHALL implement clear FSM IDLE -> CLEAR -> DONE -> IDLE.
REQ-027 SHALL, in IDLE with clr_req=1, load idx=1 and enter CLEAR at the next edge.
REQ-028 SHALL, in CLEAR, zero mem[idx] and busy[idx] on each edge and increment idx; after idx=NREG-1 is cleared, it SHALL enter DONE (NREG-1 CLEAR cycles in total).
REQ-029 SHALL, in DONE, assert clr_done=1 for exactly one cycle and then return to IDLE.
REQ-030 SHALL drive clr_busy=1 in the CLEAR and DONE states; reg_write and alloc_valid SHALL be ignored while clr_busy=1.
REQ-031 SHALL ignore clr_req in CLEAR and DONE (no restart, no queueing); clr_req held high in IDLE SHALL start a new clear.
REQ-032 SHALL, during CLEAR, return current contents on reads (some cleared, some not); bypass SHALL be disabled.
REQ-033 SHALL allow reads and busy outputs with rs1==rs2 and return identical values on both ports.

Reset
REQ-034 SHALL, while res_n=0 (asynchronous), set all mem entries to 0, all busy bits to 0, the FSM to IDLE and idx to 0.
REQ-035 SHALL drive reg1=reg2=0, busy1=busy2=0, clr_busy=0 and clr_done=0 in reset.
REQ-036 SHALL, on reset asserted mid-CLEAR, abort immediately; the first edge after res_n rises SHALL be in IDLE.

Verification
REQ-037 SHALL test: reset; write rd=5 with 0xDEADBEEF; then rs1=5 -> reg1=0xDEADBEEF; write rd=0 with 0x1234 -> reg1=0 with rs1=0.
REQ-038 SHALL test: BYPASS=1, reg_write with rd=7 and 0xA5A5A5A5 while rs2=7 -> reg2=0xA5A5A5A5 in the same cycle; BYPASS=0 -> the old value until the next cycle.
REQ-039 SHALL test: alloc rd=3, then rs1=3 -> busy1=1; write rd=3 -> busy1=0 combinationally and after the edge; alloc and write of 3 on the same edge -> busy1=1.
REQ-040 SHALL test: fill regs 1..31 with nonzero values and busy set; pulse clr_req -> clr_busy high for 32 cycles (31 CLEAR + DONE), clr_done pulses once, then all reads are 0, all busy bits are 0, and a write during the clear is dropped.
REQ-041 SHALL test: assert res_n=0 at idx=10 mid-clear -> clr_busy=0 immediately and all registers read 0; the next clr_req performs a full clear.
